// File: rtl/alu_nbit_seq.sv
// ============================================================================
//  Module      : alu_nbit_seq
//  Description : Handshaked N-bit ALU. Logic/add/SLT ops complete one cycle
//                after accept; the optional MUL is a shift-and-add multiplier
//                that takes WIDTH cycles. Optional feature macro:
//                ALU_NBIT_MUL_EN (compiles in the MUL state and datapath).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_nbit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             AInvert,
    input  logic             BInvert,
    input  logic [2:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [1:0] c_IDLE = 2'd0;
`ifdef ALU_NBIT_MUL_EN
    localparam logic [1:0] c_MUL  = 2'd1;
`endif
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b010;
    localparam logic [2:0] c_OP_XOR  = 3'b011;
    localparam logic [2:0] c_OP_ADD  = 3'b100;
    localparam logic [2:0] c_OP_ADDI = 3'b101;
    localparam logic [2:0] c_OP_SLT  = 3'b110;
`ifdef ALU_NBIT_MUL_EN
    localparam logic [2:0] c_OP_MUL  = 3'b111;

    localparam int                c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
`endif

    logic [1:0]       r_state_q,    w_state_d;
    logic [WIDTH-1:0] r_result_q,   w_result_d;
    logic             r_zero_q,     w_zero_d;
    logic             r_cout_q,     w_cout_d;
    logic             r_overflow_q, w_overflow_d;
    logic             r_illegal_q,  w_illegal_d;

    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_add_b;
    logic             w_cin;
    logic             w_is_slt;
    logic [WIDTH:0]   w_sum_ext;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_cout;
    logic             w_alu_ovf;
    logic             w_alu_ill;

`ifdef ALU_NBIT_MUL_EN
    logic [WIDTH-1:0]   r_mcand_q,  w_mcand_d;
    logic [WIDTH-1:0]   r_mplier_q, w_mplier_d;
    logic [WIDTH-1:0]   r_acc_q,    w_acc_d;
    logic [c_CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic [WIDTH-1:0]   w_mul_sum;

    assign w_mul_sum = r_acc_q + (r_mplier_q[0] ? r_mcand_q : '0);
`endif

    assign in_ready  = (r_state_q == c_IDLE);
    assign out_valid = (r_state_q == c_DONE);
    assign w_accept  = in_valid && in_ready;

    assign result    = r_result_q;
    assign zero      = r_zero_q;
    assign cout      = r_cout_q;
    assign overflow  = r_overflow_q;
    assign illegal   = r_illegal_q;

    // SLT always subtracts (a' - b'), independent of BInvert.
    always_comb begin
        w_a       = AInvert ? ~A : A;
        w_b       = BInvert ? ~B : B;
        w_is_slt  = (operation == c_OP_SLT);
        w_add_b   = w_is_slt ? ~w_b : w_b;
        w_cin     = w_is_slt ? 1'b1 : BInvert;
        w_sum_ext = {1'b0, w_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_cin};
        w_sum     = w_sum_ext[WIDTH-1:0];
        w_add_ovf = (w_a[WIDTH-1] == w_add_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

        w_alu_res  = '0;
        w_alu_cout = 1'b0;
        w_alu_ovf  = 1'b0;
        w_alu_ill  = 1'b0;
        case (operation)
            c_OP_AND: w_alu_res = w_a & w_b;
            c_OP_OR:  w_alu_res = w_a | w_b;
            c_OP_XOR: w_alu_res = w_a ^ w_b;
            c_OP_ADD, c_OP_ADDI: begin
                w_alu_res  = w_sum;
                w_alu_cout = w_sum_ext[WIDTH];
                w_alu_ovf  = w_add_ovf;
            end
            c_OP_SLT: begin
                w_alu_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
                w_alu_ovf = w_add_ovf;
            end
`ifdef ALU_NBIT_MUL_EN
            c_OP_MUL: w_alu_res = '0;
`endif
            default:  w_alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_result_d   = r_result_q;
        w_zero_d     = r_zero_q;
        w_cout_d     = r_cout_q;
        w_overflow_d = r_overflow_q;
        w_illegal_d  = r_illegal_q;
`ifdef ALU_NBIT_MUL_EN
        w_mcand_d    = r_mcand_q;
        w_mplier_d   = r_mplier_q;
        w_acc_d      = r_acc_q;
        w_cnt_d      = r_cnt_q;
`endif
        case (r_state_q)
            c_IDLE: begin
                if (w_accept) begin
`ifdef ALU_NBIT_MUL_EN
                    if (operation == c_OP_MUL) begin
                        w_state_d  = c_MUL;
                        w_mcand_d  = A;
                        w_mplier_d = B;
                        w_acc_d    = '0;
                        w_cnt_d    = '0;
                    end else begin
`endif
                        w_state_d    = c_DONE;
                        w_result_d   = w_alu_res;
                        w_zero_d     = (w_alu_res == '0);
                        w_cout_d     = w_alu_cout;
                        w_overflow_d = w_alu_ovf;
                        w_illegal_d  = w_alu_ill;
`ifdef ALU_NBIT_MUL_EN
                    end
`endif
                end
            end
`ifdef ALU_NBIT_MUL_EN
            c_MUL: begin
                w_acc_d    = w_mul_sum;
                w_mcand_d  = r_mcand_q << 1;
                w_mplier_d = r_mplier_q >> 1;
                w_cnt_d    = r_cnt_q + c_CNT_ONE;
                if (r_cnt_q == c_CNT_LAST) begin
                    w_state_d    = c_DONE;
                    w_result_d   = w_mul_sum;
                    w_zero_d     = (w_mul_sum == '0);
                    w_cout_d     = 1'b0;
                    w_overflow_d = 1'b0;
                    w_illegal_d  = 1'b0;
                end
            end
`endif
            c_DONE: begin
                if (out_ready) begin
                    w_state_d = c_IDLE;
                end
            end
            default: w_state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= c_IDLE;
            r_result_q   <= '0;
            r_zero_q     <= 1'b0;
            r_cout_q     <= 1'b0;
            r_overflow_q <= 1'b0;
            r_illegal_q  <= 1'b0;
`ifdef ALU_NBIT_MUL_EN
            r_mcand_q    <= '0;
            r_mplier_q   <= '0;
            r_acc_q      <= '0;
            r_cnt_q      <= '0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_result_q   <= w_result_d;
            r_zero_q     <= w_zero_d;
            r_cout_q     <= w_cout_d;
            r_overflow_q <= w_overflow_d;
            r_illegal_q  <= w_illegal_d;
`ifdef ALU_NBIT_MUL_EN
            r_mcand_q    <= w_mcand_d;
            r_mplier_q   <= w_mplier_d;
            r_acc_q      <= w_acc_d;
            r_cnt_q      <= w_cnt_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_nbit_seq.sv
// ============================================================================
//  Module      : tb_alu_nbit_seq
//  Description : Directed self-checking bench for alu_nbit_seq at WIDTH=8.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_nbit_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             AInvert;
    logic             BInvert;
    logic [2:0]       operation;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic             illegal;

    int total = 0;
    int bad   = 0;

    alu_nbit_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .AInvert   (AInvert),
        .BInvert   (BInvert),
        .operation (operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .cout      (cout),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] res,
                             input logic z, input logic c, input logic o, input logic il);
        check({tag, "_valid"},    64'(out_valid), 64'(v));
        check({tag, "_result"},   64'(result),    64'(res));
        check({tag, "_zero"},     64'(zero),      64'(z));
        check({tag, "_cout"},     64'(cout),      64'(c));
        check({tag, "_overflow"}, 64'(overflow),  64'(o));
        check({tag, "_illegal"},  64'(illegal),   64'(il));
    endtask

    // Presents one request for a single cycle; returns one cycle after accept.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ai, input logic bi);
        operation = op;
        A         = a;
        B         = b;
        AInvert   = ai;
        BInvert   = bi;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        A         = 8'h0F;
        B         = 8'h3C;
        AInvert   = 1'b0;
        BInvert   = 1'b0;
        operation = 3'b000;
        step();
        step();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check_out("rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // The request held during reset must not have been accepted.
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        check("rst_prio_no_valid", 64'(out_valid), 64'd0);
        check("rst_prio_in_ready", 64'(in_ready), 64'd1);

        issue(3'b000, 8'h0F, 8'h3C, 1'b0, 1'b0);
        check_out("and", 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0);
        check("and_in_ready", 64'(in_ready), 64'd0);
        consume();
        check("and_back_idle", 64'(in_ready), 64'd1);

        issue(3'b100, 8'h05, 8'h07, 1'b0, 1'b1);
        check_out("sub", 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        consume();

        issue(3'b100, 8'h7F, 8'h01, 1'b0, 1'b0);
        check_out("add_ovf", 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        consume();

        issue(3'b101, 8'hFF, 8'h01, 1'b0, 1'b0);
        check_out("addi_carry", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        consume();

        issue(3'b010, 8'hF0, 8'h30, 1'b1, 1'b0);
        check_out("or_ainv", 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
        consume();

        issue(3'b011, 8'hAA, 8'h0F, 1'b0, 1'b1);
        check_out("xor_binv", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        consume();

        issue(3'b110, 8'h80, 8'h01, 1'b0, 1'b0);
        check_out("slt_lt", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        consume();

        issue(3'b110, 8'h01, 8'h80, 1'b0, 1'b0);
        check_out("slt_ge", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        consume();

        issue(3'b110, 8'h01, 8'hFE, 1'b0, 1'b1);
        check_out("slt_binv_eq", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        consume();

        issue(3'b001, 8'h12, 8'h34, 1'b0, 1'b0);
        check_out("illegal", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        consume();

        // Backpressure: result must hold while the consumer stalls.
        issue(3'b100, 8'h7F, 8'h01, 1'b0, 1'b0);
        A = 8'h00;
        B = 8'h00;
        for (int k = 0; k < 3; k++) begin
            check_out("stall", 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        check_out("stall_end", 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        consume();
        check("stall_release_in_ready", 64'(in_ready), 64'd1);
        check("stall_release_valid", 64'(out_valid), 64'd0);

`ifdef ALU_NBIT_MUL_EN
        // 13 * 11 = 143; operand changes during the multiply must not matter.
        issue(3'b111, 8'd13, 8'd11, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            check("mul_busy_in_ready", 64'(in_ready), 64'd0);
            check("mul_busy_valid", 64'(out_valid), 64'd0);
            A = 8'($urandom);
            B = 8'($urandom);
            step();
        end
        check_out("mul", 1'b1, 8'h8F, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mul_done_in_ready", 64'(in_ready), 64'd0);
        consume();
        check("mul_back_idle", 64'(in_ready), 64'd1);

        issue(3'b111, 8'hFF, 8'hFF, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mulrst_in_ready", 64'(in_ready), 64'd1);
        check_out("mulrst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            check("mulrst_no_valid", 64'(out_valid), 64'd0);
            step();
        end
`else
        issue(3'b111, 8'd13, 8'd11, 1'b0, 1'b0);
        check_out("mul_off", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        consume();
        check("mul_off_back_idle", 64'(in_ready), 64'd1);

        // Reset while a result is pending must drop it.
        issue(3'b100, 8'h7F, 8'h01, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("donerst_in_ready", 64'(in_ready), 64'd1);
        check_out("donerst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("donerst_no_valid", 64'(out_valid), 64'd0);
            step();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_nbit_seq.md
ALU_NBIT_SEQ -- requirements
Module: alu_nbit_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal 4..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have ports A, B  input  WIDTH  operands.
REQ-007 SHALL have ports AInvert, BInvert  input  1  invert operand before op; BInvert also forces carry-in 1.
REQ-008 SHALL have port operation  input  3  000 AND, 010 OR, 011 XOR, 100 ADD, 101 ADDI, 110 SLT, 111 MUL, 001 illegal.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have ports zero, cout, overflow, illegal  output  1 each  flags for the presented result.

Function
REQ-013 SHALL accept a request when in_valid && in_ready, capturing A, B, AInvert, BInvert, operation in that cycle.
REQ-014 SHALL use states IDLE, MUL, DONE; IDLE->DONE on accept of non-MUL; IDLE->MUL on accept of MUL; MUL->DONE after WIDTH iterations; DONE->IDLE on out_ready.
REQ-015 SHALL assert in_ready only in IDLE; in_ready is low in MUL and DONE.
REQ-016 SHALL assert out_valid only in DONE; result and flags SHALL stay stable while out_valid && !out_ready.
REQ-017 Non-MUL ops SHALL have latency 1: out_valid high in the cycle after accept.
REQ-018 Operands SHALL be a' = AInvert ? ~A : A, b' = BInvert ? ~B : B; carry-in = BInvert.
REQ-019 ADD and ADDI SHALL compute identical results: result = (a' + b' + cin) mod 2^WIDTH; cout = carry out of bit WIDTH-1.
REQ-020 overflow SHALL be the signed overflow of the ADD/ADDI/SLT adder (carry into MSB xor carry out of MSB); 0 for other ops.
REQ-021 SLT SHALL compute a' + ~b' + 1 regardless of BInvert; result = {0..., sum[MSB] xor overflow} (signed less-than).
REQ-022 AND/OR/XOR SHALL be bitwise on a', b'; cout and overflow 0.
REQ-023 MUL SHALL be unsigned shift-and-add, one bit per cycle, result = low WIDTH bits of A*B; AInvert/BInvert ignored; out_valid rises WIDTH+1 cycles after accept; cout/overflow 0.
REQ-024 zero SHALL be 1 iff result == 0, for every op.
REQ-025 Operation 001 SHALL complete with latency 1, result 0, zero 1, illegal 1; illegal is 0 for all other ops.
REQ-026 Input changes while not in IDLE SHALL not affect the in-flight result.

Reset
REQ-027 On reset the FSM SHALL enter IDLE on the next edge; outputs SHALL be in_ready 1, out_valid 0, result 0, zero 0, cout 0, overflow 0, illegal 0.
REQ-028 Reset asserted mid-MUL or in DONE SHALL abandon the operation; no out_valid for it is ever produced.
REQ-029 Reset SHALL take priority over a simultaneous in_valid; the request is not accepted.

Configuration
REQ-030 Macro ALU_NBIT_MUL_EN SHALL compile in the MUL state and multiplier datapath.
REQ-031 Without ALU_NBIT_MUL_EN, operation 111 SHALL be treated exactly as 001 (latency 1, result 0, zero 1, illegal 1) and state MUL SHALL not exist.

Verification (WIDTH=8)
REQ-032 AND A=0x0F B=0x3C accepted at cycle t -> out_valid at t+1, result 0x0C, zero 0, illegal 0.
REQ-033 SUB (op 100, BInvert 1) A=0x05 B=0x07 -> result 0xFE, cout 0, overflow 0; ADD 0x7F+0x01 -> 0x80, overflow 1.
REQ-034 SLT A=0x80 B=0x01 -> result 0x01; SLT A=0x01 B=0x80 -> result 0x00, zero 1.
REQ-035 MUL A=13 B=11 with ALU_NBIT_MUL_EN -> in_ready low 9 cycles, result 0x8F at t+9; without macro -> result 0, illegal 1 at t+1.
REQ-036 out_ready held low 3 cycles after out_valid -> result/flags stable, in_ready 0; out_ready high -> in_ready 1 next cycle.
REQ-037 reset pulsed at cycle 4 of a MUL -> next cycle in_ready 1, out_valid 0, all outputs at reset values.
